// File: rtl/smg_scan_decoder.sv
// smg_scan_decoder: recovers the 4-digit value shown on a multiplexed,
// active-low 7-segment display by watching its digit-select (sm_wei) and
// segment (sm_duan) lines, and publishes each complete frame.
// Optional feature: define SMG_DP_CAPTURE_EN to capture the decimal point
// of every digit; without it dp reads 4'h0 and duan[7] is ignored.
module smg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sm_wei,
    input  logic [7:0]  sm_duan,
    output logic [15:0] data,
    output logic [3:0]  blank,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    localparam logic [7:0]  STABLE_LIMIT = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMER_LAST   = 16'(FRAME_TIMEOUT - 1);

    logic [3:0]  wei_r;
    logic [7:0]  duan_r;
    logic        dp_key;
    logic [11:0] key;
    logic [11:0] key_q;
    logic        changed;

    logic        one_hot;
    logic [1:0]  idx;

    logic [3:0]  nib;
    logic        seg_ok;
    logic        seg_blank;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic        cap;
    logic        cap_ok;

    logic [3:0]  mask;
    logic [3:0]  mask_n;
    logic [3:0]  cap_bit;
    logic [3:0]  merged;
    logic [15:0] timer;
    logic [15:0] timer_n;
    logic        complete;
    logic        expire;
    logic        timeout_n;

    logic [15:0] sh_data;
    logic [3:0]  sh_blank;

`ifdef SMG_DP_CAPTURE_EN
    logic [3:0]  sh_dp;
    assign dp_key = duan_r[7];
`else
    logic        unused_dp_bit;
    assign dp_key        = 1'b1;
    assign unused_dp_bit = duan_r[7];
    assign dp            = 4'h0;
`endif

    // The stability key deliberately leaves out the decimal point when it is not captured.
    assign key     = {wei_r, dp_key, duan_r[6:0]};
    assign changed = (key != key_q);

    // Input registers plus the one-cycle-old copy used to detect any change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wei_r  <= 4'hF;
            duan_r <= 8'hFF;
            key_q  <= 12'hFFF;
        end else begin
            wei_r  <= sm_wei;
            duan_r <= sm_duan;
            key_q  <= key;
        end
    end

    // Turn an active-low one-hot select into a digit index.
    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (wei_r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    // Active-low hex glyph decoder; all segments off reads as a blank F.
    always_comb begin
        nib       = 4'h0;
        seg_ok    = 1'b1;
        seg_blank = 1'b0;
        case (duan_r[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h7F: begin
                nib       = 4'hF;
                seg_blank = 1'b1;
            end
            default: seg_ok = 1'b0;
        endcase
    end

    // Settle FSM: a digit is captured once its select and segments held for STABLE_CYCLES.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end else begin
                    cnt_n = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_n = ST_IDLE;
                    cnt_n   = 8'd0;
                end else if (changed) begin
                    cnt_n = 8'd1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_HELD: begin
                if (!one_hot) begin
                    state_n = ST_IDLE;
                    cnt_n   = 8'd0;
                end else if (changed) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
        if (state_n == ST_SETTLE && cnt_n == STABLE_LIMIT) begin
            cap     = 1'b1;
            state_n = ST_HELD;
        end
    end

    assign cap_ok  = cap & seg_ok;
    assign cap_bit = cap_ok ? (4'b0001 << idx) : 4'b0000;
    assign merged  = mask | cap_bit;

    // Frame bookkeeping: completion beats an expiring timer, even on the same edge.
    always_comb begin
        complete  = (mask == 4'hF);
        expire    = (mask != 4'h0) && !complete && (timer == TIMER_LAST);
        mask_n    = merged;
        timer_n   = (mask == 4'h0) ? 16'd0 : timer + 16'd1;
        timeout_n = 1'b0;
        if (complete) begin
            mask_n  = cap_bit;
            timer_n = 16'd0;
        end else if (expire && merged != 4'hF) begin
            mask_n    = 4'h0;
            timer_n   = 16'd0;
            timeout_n = 1'b1;
        end
    end

    // State, shadow frame, published outputs and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            mask        <= 4'h0;
            timer       <= 16'd0;
            sh_data     <= 16'h0000;
            sh_blank    <= 4'h0;
            data        <= 16'h0000;
            blank       <= 4'h0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            timeout     <= 1'b0;
`ifdef SMG_DP_CAPTURE_EN
            sh_dp       <= 4'h0;
            dp          <= 4'h0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mask        <= mask_n;
            timer       <= timer_n;
            frame_valid <= complete;
            seg_error   <= cap & ~seg_ok;
            timeout     <= timeout_n;
            if (cap_ok) begin
                sh_data[{idx, 2'b00} +: 4] <= nib;
                sh_blank[idx]              <= seg_blank;
`ifdef SMG_DP_CAPTURE_EN
                sh_dp[idx]                 <= ~duan_r[7];
`endif
            end
            if (complete) begin
                data  <= sh_data;
                blank <= sh_blank;
`ifdef SMG_DP_CAPTURE_EN
                dp    <= sh_dp;
`endif
            end
        end
    end

endmodule

// File: doc/smg_scan_decoder.md
SMG_SCAN_DECODER -- requirements
Module: smg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: cycles that wei/duan must stay unchanged before a digit is captured (range 1..255).
REQ-002 Parameter FRAME_TIMEOUT, default 65535: cycles allowed for completing a 4-digit frame (range 16..65535).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sm_wei  input  4  digit select, active-low one-hot; bit i low selects digit i.
REQ-006 sm_duan  input  8  segments, active-low; bit order {dp,g,f,e,d,c,b,a}.
REQ-007 data  output  16  last complete frame; digit i in data[4i+3:4i].
REQ-008 blank  output  4  bit i set when digit i of the last frame was all-segments-off.
REQ-009 dp  output  4  decimal-point state per digit of the last frame (see REQ-029).
REQ-010 frame_valid  output  1  one-cycle pulse when data/blank/dp update.
REQ-011 seg_error  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-012 timeout  output  1  one-cycle pulse when a partial frame is abandoned.

Function
REQ-013 Inputs registered once before use; all latencies below count from that registered copy.
REQ-014 States: IDLE (wei not one-hot-low), SETTLE (counting stability), HELD (digit captured, waiting for wei/duan change).
REQ-015 IDLE -> SETTLE when wei is exactly one-hot-low; stability counter loads 1.
REQ-016 In SETTLE, counter increments while {wei,duan} equals the previous cycle; any change restarts at 1 (or goes to IDLE if wei not one-hot).
REQ-017 Capture when counter reaches STABLE_CYCLES: decode duan[6:0], state -> HELD.
REQ-018 HELD -> SETTLE (counter 1) on any change of {wei,duan} with wei one-hot; -> IDLE otherwise; no re-capture while in HELD.
REQ-019 Decode: standard hex 0-F glyphs (b,d lowercase; A,C,E,F uppercase) to nibble; all-off -> nibble F with blank bit set.
REQ-020 Any other pattern: seg_error pulses the cycle after capture, the digit is not marked captured, nibble discarded.
REQ-021 Successful capture writes nibble/blank/dp into shadow slot i and sets mask bit i; recapture of the same i overwrites.
REQ-022 When mask becomes 4'b1111, next cycle: shadow -> data/blank/dp, frame_valid pulses, mask clears.
REQ-023 Frame timer runs while mask is nonzero; at FRAME_TIMEOUT cycles without completion, mask clears, timeout pulses, outputs unchanged.
REQ-024 Frame timer restarts on each frame completion and whenever mask goes from zero to nonzero.
REQ-025 Capture completing a frame in the same cycle the timer expires: frame completion wins, no timeout pulse.

Reset
REQ-026 rst high at any clock edge: state IDLE, counters 0, mask 0, shadow 0.
REQ-027 Reset values: data 16'h0000, blank 4'h0, dp 4'h0, frame_valid 0, seg_error 0, timeout 0.
REQ-028 Reset mid-frame discards partial frame; no pulse is emitted for it after reset release.

Configuration
REQ-029 Macro SMG_DP_CAPTURE_EN: defined -> dp[i] = ~duan[7] sampled at capture of digit i; undefined -> dp tied 4'h0 and duan[7] ignored (dp changes never restart SETTLE).

Verification
REQ-030 Scan digits 0..3 showing "1","2","3","4" (duan 8'hF9,A4,B0,99), 8 cycles each, STABLE_CYCLES=4 -> one frame_valid, data=16'h4321, blank=0.
REQ-031 Digit 2 duan=8'hFF, others "0" (8'hC0) -> data=16'h0F00, blank=4'b0100.
REQ-032 Digit 1 duan=8'hFE (segment a only) -> seg_error pulse, mask bit 1 clear, no frame_valid until valid digit 1 arrives.
REQ-033 Glitch: duan toggles every 2 cycles on digit 0 with STABLE_CYCLES=4 -> no capture; stable 4 cycles then -> capture.
REQ-034 Scan only digits 0..2, FRAME_TIMEOUT=16 -> timeout pulse 16 cycles after first capture, data unchanged.
REQ-035 Assert rst during digit 3 of a frame -> outputs at reset values, no frame_valid; following full scan -> normal frame.
